// File: rtl/wfg_ctrl_fsm.sv
// Waveform-generator main controller: sequences LUT loading from a valid/ready
// sample stream, then drives per-channel fixed or linear-sweep frequency steps.
module wfg_ctrl_fsm #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned FREQ_W  = 14,
    parameter int unsigned DWELL_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_i,
    input  logic                     load_req_i,
    input  logic                     run_req_i,
    input  logic                     stop_req_i,
    input  logic [N_CH-1:0]          mode_i,
    input  logic [N_CH*FREQ_W-1:0]   freq_start_i,
    input  logic [N_CH*FREQ_W-1:0]   freq_stop_i,
    input  logic [FREQ_W-1:0]        sweep_step_i,
    input  logic [DWELL_W-1:0]       dwell_i,
    input  logic                     s_valid_i,
    input  logic [DATA_W-1:0]        s_data_i,
    output logic                     s_ready_o,
    output logic                     nco_we_o,
    output logic [ADDR_W-1:0]        nco_addr_o,
    output logic [DATA_W-1:0]        nco_data_o,
    output logic                     nco_clr_o,
    output logic [N_CH*FREQ_W-1:0]   nco_freq_step_o,
    output logic                     busy_o,
    output logic                     load_done_o,
    output logic [2:0]               state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_RUN  = 3'd3,
        S_DUMP = 3'd4
    } state_t;

    state_t                   state_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [DWELL_W-1:0]       dwell_q;
    logic [N_CH*FREQ_W-1:0]   freq_q;
    logic [N_CH*FREQ_W-1:0]   freq_upd;
    logic                     s_ready_q;
    logic                     we_q;
    logic [ADDR_W-1:0]        nco_addr_q;
    logic [DATA_W-1:0]        nco_data_q;
    logic                     clr_q;
    logic                     done_q;
    logic                     hs;
    logic                     last_beat;
    logic                     stop_any;

    assign hs        = s_valid_i & s_ready_q;
    assign last_beat = (addr_q == {ADDR_W{1'b1}});
    assign stop_any  = stop_req_i | ~en_i;

    // Per-channel value after a dwell terminal count; sum carries one extra bit so
    // an overflowing step restarts the sawtooth instead of wrapping.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [FREQ_W-1:0] f_cur;
        logic [FREQ_W-1:0] f_start;
        logic [FREQ_W-1:0] f_stop;
        logic [FREQ_W:0]   f_sum;

        assign f_cur   = freq_q[k*FREQ_W +: FREQ_W];
        assign f_start = freq_start_i[k*FREQ_W +: FREQ_W];
        assign f_stop  = freq_stop_i[k*FREQ_W +: FREQ_W];
        assign f_sum   = {1'b0, f_cur} + {1'b0, sweep_step_i};
        assign freq_upd[k*FREQ_W +: FREQ_W] =
            (!mode_i[k] || (f_sum > {1'b0, f_stop})) ? f_start : f_sum[FREQ_W-1:0];
    end

    // Controller state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            dwell_q    <= '0;
            freq_q     <= '0;
            s_ready_q  <= 1'b0;
            we_q       <= 1'b0;
            nco_addr_q <= '0;
            nco_data_q <= '0;
            clr_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            clr_q  <= 1'b0;
            done_q <= 1'b0;

            // An accepted beat is always written, even on the way to DUMP.
            if (hs) begin
                we_q       <= 1'b1;
                nco_addr_q <= addr_q;
                nco_data_q <= s_data_i;
                addr_q     <= addr_q + ADDR_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (en_i && load_req_i) begin
                        state_q   <= S_LOAD;
                        addr_q    <= '0;
                        s_ready_q <= 1'b1;
                    end else if (en_i && run_req_i) begin
                        state_q <= S_WAIT;
                        clr_q   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (stop_any) begin
                        state_q   <= S_DUMP;
                        s_ready_q <= 1'b0;
                        clr_q     <= 1'b1;
                    end else if (hs && last_beat) begin
                        state_q   <= S_IDLE;
                        s_ready_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (stop_req_i) begin
                        state_q <= S_DUMP;
                        clr_q   <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                        freq_q  <= freq_start_i;
                        dwell_q <= '0;
                    end
                end
                S_RUN: begin
                    if (stop_any) begin
                        state_q <= S_DUMP;
                        clr_q   <= 1'b1;
                        freq_q  <= '0;
                    end else if (dwell_q >= dwell_i) begin
                        dwell_q <= '0;
                        freq_q  <= freq_upd;
                    end else begin
                        dwell_q <= dwell_q + DWELL_W'(1);
                    end
                end
                S_DUMP: begin
                    state_q   <= S_IDLE;
                    freq_q    <= '0;
                    dwell_q   <= '0;
                    s_ready_q <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    freq_q    <= '0;
                    s_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready_o       = s_ready_q;
    assign nco_we_o        = we_q;
    assign nco_addr_o      = nco_addr_q;
    assign nco_data_o      = nco_data_q;
    assign nco_clr_o       = clr_q;
    assign nco_freq_step_o = freq_q;
    assign load_done_o     = done_q;
    assign busy_o          = (state_q != S_IDLE);
    assign state_o         = state_q;

endmodule

// File: tb/tb_wfg_ctrl_fsm.sv
// Self-checking bench for wfg_ctrl_fsm: directed and randomized load/run scenarios
// checked against a sequence-level model of the sweep and load behaviour.
module tb_wfg_ctrl_fsm;

    localparam int unsigned N_CH    = 2;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned FREQ_W  = 14;
    localparam int unsigned DWELL_W = 16;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   en_i;
    logic                   load_req_i;
    logic                   run_req_i;
    logic                   stop_req_i;
    logic [N_CH-1:0]        mode_i;
    logic [N_CH*FREQ_W-1:0] freq_start_i;
    logic [N_CH*FREQ_W-1:0] freq_stop_i;
    logic [FREQ_W-1:0]      sweep_step_i;
    logic [DWELL_W-1:0]     dwell_i;
    logic                   s_valid_i;
    logic [DATA_W-1:0]      s_data_i;
    logic                   s_ready_o;
    logic                   nco_we_o;
    logic [ADDR_W-1:0]      nco_addr_o;
    logic [DATA_W-1:0]      nco_data_o;
    logic                   nco_clr_o;
    logic [N_CH*FREQ_W-1:0] nco_freq_step_o;
    logic                   busy_o;
    logic                   load_done_o;
    logic [2:0]             state_o;

    int total = 0;
    int bad   = 0;

    wfg_ctrl_fsm #(
        .N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FREQ_W(FREQ_W), .DWELL_W(DWELL_W)
    ) dut (
        .clk(clk), .reset(reset), .en_i(en_i), .load_req_i(load_req_i),
        .run_req_i(run_req_i), .stop_req_i(stop_req_i), .mode_i(mode_i),
        .freq_start_i(freq_start_i), .freq_stop_i(freq_stop_i),
        .sweep_step_i(sweep_step_i), .dwell_i(dwell_i), .s_valid_i(s_valid_i),
        .s_data_i(s_data_i), .s_ready_o(s_ready_o), .nco_we_o(nco_we_o),
        .nco_addr_o(nco_addr_o), .nco_data_o(nco_data_o), .nco_clr_o(nco_clr_o),
        .nco_freq_step_o(nco_freq_step_o), .busy_o(busy_o),
        .load_done_o(load_done_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FREQ_W-1:0] ch(input int k);
        return nco_freq_step_o[k*FREQ_W +: FREQ_W];
    endfunction

    // Sawtooth model: the reachable values are start, start+step, ... up to stop;
    // the k-th dwell period shows entry (k mod count) of that list.
    function automatic int exp_freq(input bit m, input int st, input int sp,
                                    input int stp, input int dw, input int t);
        int k;
        int n;
        if (!m || st > sp || stp == 0) return st;
        k = t / (dw + 1);
        n = (sp - st) / stp + 1;
        return st + (k % n) * stp;
    endfunction

    task automatic load_seq(input int n_stop, input bit rnd, input bit beat_with_stop);
        int beats = 0;
        bit gapped = 1'b0;
        bit fin = 1'b0;
        logic [ADDR_W-1:0] la = '0;
        logic [DATA_W-1:0] ld = '0;
        load_req_i = 1'b1;
        run_req_i  = 1'b1;
        tick();
        load_req_i = 1'b0;
        run_req_i  = 1'b0;
        chk("load_state", 64'(state_o), 64'd1);
        for (int c = 0; c < 200 && !fin; c++) begin
            bit v;
            bit stop_now;
            logic [DATA_W-1:0] d;
            stop_now = (n_stop < int'(DEPTH)) && (beats == n_stop);
            if (stop_now) v = beat_with_stop;
            else if (rnd) v = ($urandom_range(0, 2) != 0);
            else if (beats == 3 && !gapped) begin v = 1'b0; gapped = 1'b1; end
            else v = 1'b1;
            d = rnd ? DATA_W'($urandom) : DATA_W'(8'h10 + beats);
            chk("load_ready", 64'(s_ready_o), 64'd1);
            chk("load_busy", 64'(busy_o), 64'd1);
            s_valid_i  = v;
            s_data_i   = d;
            stop_req_i = stop_now;
            tick();
            s_valid_i  = 1'b0;
            stop_req_i = 1'b0;
            chk("load_we", 64'(nco_we_o), 64'(v));
            if (v) begin
                la = ADDR_W'(beats);
                ld = d;
                beats++;
            end
            chk("load_addr", 64'(nco_addr_o), 64'(la));
            chk("load_data", 64'(nco_data_o), 64'(ld));
            if (stop_now) begin
                chk("stop_state", 64'(state_o), 64'd4);
                chk("stop_clr", 64'(nco_clr_o), 64'd1);
                chk("stop_ready", 64'(s_ready_o), 64'd0);
                chk("stop_done", 64'(load_done_o), 64'd0);
                tick();
                chk("stop_idle", 64'(state_o), 64'd0);
                chk("stop_we_after", 64'(nco_we_o), 64'd0);
                chk("stop_done_after", 64'(load_done_o), 64'd0);
                chk("stop_clr_after", 64'(nco_clr_o), 64'd0);
                fin = 1'b1;
            end else if (beats == int'(DEPTH)) begin
                chk("done_pulse", 64'(load_done_o), 64'd1);
                chk("done_state", 64'(state_o), 64'd0);
                chk("done_busy", 64'(busy_o), 64'd0);
                chk("done_ready", 64'(s_ready_o), 64'd0);
                tick();
                chk("done_low_after", 64'(load_done_o), 64'd0);
                chk("we_low_after", 64'(nco_we_o), 64'd0);
                fin = 1'b1;
            end else begin
                chk("done_low", 64'(load_done_o), 64'd0);
            end
        end
        chk("load_finished", 64'(fin), 64'd1);
    endtask

    task automatic set_cfg(input bit [1:0] m, input int st0, input int st1, input int sp0,
                           input int sp1, input int stp, input int dw);
        mode_i       = m;
        freq_start_i = {FREQ_W'(st1), FREQ_W'(st0)};
        freq_stop_i  = {FREQ_W'(sp1), FREQ_W'(sp0)};
        sweep_step_i = FREQ_W'(stp);
        dwell_i      = DWELL_W'(dw);
    endtask

    // Enters RUN via WAIT and leaves the bench at the first RUN cycle.
    task automatic start_run();
        run_req_i = 1'b1;
        tick();
        run_req_i = 1'b0;
        chk("wait_state", 64'(state_o), 64'd2);
        chk("wait_clr", 64'(nco_clr_o), 64'd1);
        chk("wait_freq", 64'(nco_freq_step_o), 64'd0);
        tick();
        chk("run_state", 64'(state_o), 64'd3);
        chk("run_clr", 64'(nco_clr_o), 64'd0);
    endtask

    task automatic run_seq(input bit [1:0] m, input int st0, input int st1, input int sp0,
                           input int sp1, input int stp, input int dw, input int ncyc,
                           input bit use_en);
        set_cfg(m, st0, st1, sp0, sp1, stp, dw);
        start_run();
        for (int t = 0; t < ncyc; t++) begin
            chk("run_ch0", 64'(ch(0)), 64'(exp_freq(m[0], st0, sp0, stp, dw, t)));
            chk("run_ch1", 64'(ch(1)), 64'(exp_freq(m[1], st1, sp1, stp, dw, t)));
            chk("run_busy", 64'(busy_o), 64'd1);
            load_req_i = 1'($urandom_range(0, 1));
            tick();
        end
        load_req_i = 1'b0;
        if (use_en) en_i = 1'b0;
        else stop_req_i = 1'b1;
        tick();
        chk("dump_state", 64'(state_o), 64'd4);
        chk("dump_clr", 64'(nco_clr_o), 64'd1);
        chk("dump_freq", 64'(nco_freq_step_o), 64'd0);
        chk("dump_ready", 64'(s_ready_o), 64'd0);
        en_i       = 1'b1;
        stop_req_i = 1'b0;
        tick();
        chk("post_state", 64'(state_o), 64'd0);
        chk("post_clr", 64'(nco_clr_o), 64'd0);
        chk("post_busy", 64'(busy_o), 64'd0);
        chk("post_freq", 64'(nco_freq_step_o), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        en_i       = 1'b0;
        load_req_i = 1'b0;
        run_req_i  = 1'b0;
        stop_req_i = 1'b0;
        s_valid_i  = 1'b0;
        s_data_i   = '0;
        set_cfg(2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", 64'(s_ready_o), 64'd0);
        chk("rst_we", 64'(nco_we_o), 64'd0);
        chk("rst_addr", 64'(nco_addr_o), 64'd0);
        chk("rst_data", 64'(nco_data_o), 64'd0);
        chk("rst_clr", 64'(nco_clr_o), 64'd0);
        chk("rst_freq", 64'(nco_freq_step_o), 64'd0);
        chk("rst_done", 64'(load_done_o), 64'd0);
        reset = 1'b0;
        en_i  = 1'b1;
        tick();
        chk("idle_state", 64'(state_o), 64'd0);

        load_seq(DEPTH, 1'b0, 1'b0);
        load_seq(3, 1'b0, 1'b0);
        load_seq(3, 1'b0, 1'b1);
        load_seq(DEPTH, 1'b1, 1'b0);

        // Disabled block ignores requests.
        en_i      = 1'b0;
        run_req_i = 1'b1;
        tick();
        chk("en_gate_state", 64'(state_o), 64'd0);
        run_req_i = 1'b0;
        en_i      = 1'b1;
        tick();

        run_seq(2'b00, 100, 250, 0, 0, 0, 0, 50, 1'b0);
        run_seq(2'b01, 100, 250, 130, 0, 10, 3, 40, 1'b0);
        run_seq(2'b01, 16380, 7, 16383, 0, 5, 0, 20, 1'b1);

        // Reset in the middle of a sweep, then a clean restart.
        set_cfg(2'b01, 100, 250, 130, 0, 10, 3);
        start_run();
        for (int t = 0; t < 8; t++) tick();
        chk("pre_rst_ch0", 64'(ch(0)), 64'd120);
        reset = 1'b1;
        tick();
        chk("mid_rst_state", 64'(state_o), 64'd0);
        chk("mid_rst_freq", 64'(nco_freq_step_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_clr", 64'(nco_clr_o), 64'd0);
        reset = 1'b0;
        tick();
        run_seq(2'b01, 100, 250, 130, 0, 10, 3, 12, 1'b0);

        // Randomized configurations.
        for (int i = 0; i < 6; i++) begin
            int st[2];
            int sp[2];
            int stp;
            int dw;
            for (int k = 0; k < 2; k++) begin
                st[k] = int'($urandom_range(0, 16383));
                if ($urandom_range(0, 3) == 0) sp[k] = int'($urandom_range(0, 16383));
                else begin
                    sp[k] = st[k] + int'($urandom_range(0, 300));
                    if (sp[k] > 16383) sp[k] = 16383;
                end
            end
            stp = int'($urandom_range(0, 40));
            dw  = int'($urandom_range(0, 3));
            run_seq(2'($urandom_range(0, 3)), st[0], st[1], sp[0], sp[1], stp, dw, 40,
                    1'($urandom_range(0, 1)));
        end

        // Stop while in WAIT.
        run_req_i = 1'b1;
        tick();
        run_req_i  = 1'b0;
        chk("wstop_wait", 64'(state_o), 64'd2);
        stop_req_i = 1'b1;
        tick();
        stop_req_i = 1'b0;
        chk("wstop_dump", 64'(state_o), 64'd4);
        chk("wstop_clr", 64'(nco_clr_o), 64'd1);
        chk("wstop_freq", 64'(nco_freq_step_o), 64'd0);
        tick();
        chk("wstop_idle", 64'(state_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
